// File: rtl/iq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : iq_pkg
// Purpose  : Shared types and default sizing for the age-ordered issue queue.
// Revision : 1.0 - initial release
// ============================================================================
package iq_pkg;

   localparam int IQ_DEPTH      = 16;
   localparam int IQ_DISPATCH_W = 4;
   localparam int IQ_ISSUE_W    = 4;
   localparam int IQ_WAKEUP_W   = 4;
   localparam int IQ_PRF_IDX_W  = 6;
   localparam int IQ_PAYLOAD_W  = 32;

   // Per-entry contents that need no reset. The valid bit and the age row
   // live in separately reset arrays inside the queue. Field widths follow
   // the package defaults, so a different tag/payload width is made here.
   typedef struct packed {
      logic [IQ_PAYLOAD_W-1:0] payload;
      logic [IQ_PRF_IDX_W-1:0] src1;
      logic [IQ_PRF_IDX_W-1:0] src2;
      logic                    src1_rdy;
      logic                    src2_rdy;
   } iq_entry_t;

endpackage
`default_nettype wire

// File: rtl/issue_queue_age_if.sv
`default_nettype none
// ============================================================================
// Module   : issue_queue_age_if
// Purpose  : Dispatch / wakeup / issue bundle of the age-ordered issue queue.
//            master = the pipeline around the queue, slave = the queue.
// Revision : 1.0 - initial release
// ============================================================================
interface issue_queue_age_if
   import iq_pkg::*;
#(
   parameter int DEPTH      = IQ_DEPTH,
   parameter int DISPATCH_W = IQ_DISPATCH_W,
   parameter int ISSUE_W    = IQ_ISSUE_W,
   parameter int WAKEUP_W   = IQ_WAKEUP_W,
   parameter int PRF_IDX_W  = IQ_PRF_IDX_W,
   parameter int PAYLOAD_W  = IQ_PAYLOAD_W
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   // dispatch
   logic [DISPATCH_W-1:0]                dis_valid;
   logic [DISPATCH_W-1:0][PAYLOAD_W-1:0] dis_payload;
   logic [DISPATCH_W-1:0][PRF_IDX_W-1:0] dis_src1;
   logic [DISPATCH_W-1:0][PRF_IDX_W-1:0] dis_src2;
   logic [DISPATCH_W-1:0]                dis_src1_rdy;
   logic [DISPATCH_W-1:0]                dis_src2_rdy;
   // wakeup broadcast
   logic [WAKEUP_W-1:0]                  wk_valid;
   logic [WAKEUP_W-1:0][PRF_IDX_W-1:0]   wk_index;
   // issue
   logic [ISSUE_W-1:0]                   ex_busy;
   logic [ISSUE_W-1:0]                   iss_valid;
   logic [ISSUE_W-1:0][PAYLOAD_W-1:0]    iss_payload;
   // occupancy
   logic                                 iq_full;
   logic [CNT_W-1:0]                     free_count;

   modport master (
      output dis_valid, dis_payload, dis_src1, dis_src2, dis_src1_rdy, dis_src2_rdy,
      output wk_valid, wk_index, ex_busy,
      input  iss_valid, iss_payload, iq_full, free_count
   );

   modport slave (
      input  dis_valid, dis_payload, dis_src1, dis_src2, dis_src1_rdy, dis_src2_rdy,
      input  wk_valid, wk_index, ex_busy,
      output iss_valid, iss_payload, iq_full, free_count
   );

endinterface
`default_nettype wire

// File: rtl/iq_age_select.sv
`default_nettype none
// ============================================================================
// Module   : iq_age_select
// Purpose  : Oldest-first multi-port picker. age_i[i][j]=1 means entry i is
//            older than entry j. Each non-busy port, in port order, grabs the
//            oldest ready entry not already taken by a lower port.
// Revision : 1.0 - initial release
// ============================================================================
module iq_age_select #(
   parameter int DEPTH   = 16,
   parameter int ISSUE_W = 4
) (
   input  logic [DEPTH-1:0][DEPTH-1:0] age_i,
   input  logic [DEPTH-1:0]            ready_i,
   input  logic [ISSUE_W-1:0]          busy_i,
   output logic [ISSUE_W-1:0][DEPTH-1:0] grant_o
);

   // Sequential-by-port pick; a busy port leaves its candidate for the next port.
   always_comb begin
      logic [DEPTH-1:0] remaining;
      logic             done;
      logic             older;
      remaining = ready_i;
      grant_o   = '0;
      done      = 1'b0;
      older     = 1'b0;
      for (int i = 0; i < ISSUE_W; i++) begin
         if (!busy_i[i]) begin
            done = 1'b0;
            for (int e = 0; e < DEPTH; e++) begin
               if (remaining[e] && !done) begin
                  older = 1'b0;
                  for (int j = 0; j < DEPTH; j++) begin
                     if (remaining[j] && age_i[j][e]) begin
                        older = 1'b1;
                     end
                  end
                  if (!older) begin
                     grant_o[i][e] = 1'b1;
                     done          = 1'b1;
                  end
               end
            end
            remaining = remaining & ~grant_o[i];
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/issue_queue_age.sv
`default_nettype none
// ============================================================================
// Module   : issue_queue_age
// Purpose  : Age-matrix ordered issue queue with multi-port dispatch, tag
//            wakeup and oldest-first multi-port issue.
// Revision : 1.0 - initial release
// ============================================================================
module issue_queue_age
   import iq_pkg::*;
#(
   parameter int DEPTH      = IQ_DEPTH,
   parameter int DISPATCH_W = IQ_DISPATCH_W,
   parameter int ISSUE_W    = IQ_ISSUE_W,
   parameter int WAKEUP_W   = IQ_WAKEUP_W,
   parameter int PRF_IDX_W  = IQ_PRF_IDX_W,
   parameter int PAYLOAD_W  = IQ_PAYLOAD_W
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            flush_i,
   issue_queue_age_if.slave bus_if
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = IDX_W + 1;

   logic [DEPTH-1:0]            valid_q, valid_d;
   logic [DEPTH-1:0][DEPTH-1:0] age_q, age_d;
   iq_entry_t                   entry_q [DEPTH];
   iq_entry_t                   entry_d [DEPTH];

   logic [DEPTH-1:0]                  ready;
   logic [ISSUE_W-1:0][DEPTH-1:0]     grant;
   logic [DEPTH-1:0]                  issued;
   logic [CNT_W-1:0]                  free_count;
   logic                              full;
   logic [DISPATCH_W-1:0]             alloc_en;
   logic [DISPATCH_W-1:0][IDX_W-1:0]  alloc_idx;
   logic [ISSUE_W-1:0]                iss_valid;
   logic [ISSUE_W-1:0][PAYLOAD_W-1:0] iss_payload;

   // Full-width tag compare against every broadcast port (tag 0 included).
   function automatic logic wake_hit(
      input logic [PRF_IDX_W-1:0]               tag,
      input logic [WAKEUP_W-1:0]                wv,
      input logic [WAKEUP_W-1:0][PRF_IDX_W-1:0] widx
   );
      logic hit;
      hit = 1'b0;
      for (int k = 0; k < WAKEUP_W; k++) begin
         hit = hit | (wv[k] && (widx[k] == tag));
      end
      return hit;
   endfunction

   // Occupancy from registered valid bits only.
   always_comb begin
      free_count = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (!valid_q[i]) begin
            free_count = free_count + CNT_W'(1);
         end
      end
      full = (free_count < CNT_W'(DISPATCH_W));
   end

   // Lowest free slots to requesting ports in port order; slots freed this
   // cycle are still valid in valid_q and therefore not handed out yet.
   always_comb begin
      logic [DEPTH-1:0] taken;
      logic             found;
      taken     = '0;
      found     = 1'b0;
      alloc_en  = '0;
      alloc_idx = '0;
      for (int p = 0; p < DISPATCH_W; p++) begin
         if (bus_if.dis_valid[p] && !full && !flush_i) begin
            found = 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
               if (!found && !valid_q[i] && !taken[i]) begin
                  found        = 1'b1;
                  taken[i]     = 1'b1;
                  alloc_idx[p] = IDX_W'(i);
               end
            end
            alloc_en[p] = found;
         end
      end
   end

   // Ready vector feeds the picker; all inputs come from registers.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         ready[i] = valid_q[i] & entry_q[i].src1_rdy & entry_q[i].src2_rdy;
      end
   end

   iq_age_select #(
      .DEPTH   (DEPTH),
      .ISSUE_W (ISSUE_W)
   ) u_select (
      .age_i   (age_q),
      .ready_i (ready),
      .busy_i  (bus_if.ex_busy),
      .grant_o (grant)
   );

   // Issue outputs: one-hot mux of payloads; flush suppresses every port.
   always_comb begin
      issued = '0;
      for (int i = 0; i < ISSUE_W; i++) begin
         iss_valid[i]   = (|grant[i]) & ~flush_i;
         iss_payload[i] = '0;
         for (int e = 0; e < DEPTH; e++) begin
            if (grant[i][e]) begin
               iss_payload[i] = iss_payload[i] | entry_q[e].payload;
            end
         end
         if (!flush_i) begin
            issued = issued | grant[i];
         end
      end
   end

   assign bus_if.iss_valid   = iss_valid;
   assign bus_if.iss_payload = iss_payload;
   assign bus_if.iq_full     = full;
   assign bus_if.free_count  = free_count;

   // Next state: free issued slots, apply wakeups, write new entries, and
   // make each new entry youngest (later ports younger than earlier ones).
   always_comb begin
      valid_d = valid_q & ~issued;
      age_d   = age_q;
      entry_d = entry_q;
      for (int i = 0; i < DEPTH; i++) begin
         if (valid_q[i]) begin
            entry_d[i].src1_rdy = entry_q[i].src1_rdy |
               wake_hit(entry_q[i].src1, bus_if.wk_valid, bus_if.wk_index);
            entry_d[i].src2_rdy = entry_q[i].src2_rdy |
               wake_hit(entry_q[i].src2, bus_if.wk_valid, bus_if.wk_index);
         end
      end
      for (int p = 0; p < DISPATCH_W; p++) begin
         if (alloc_en[p]) begin
            valid_d[alloc_idx[p]]          = 1'b1;
            entry_d[alloc_idx[p]].payload  = bus_if.dis_payload[p];
            entry_d[alloc_idx[p]].src1     = bus_if.dis_src1[p];
            entry_d[alloc_idx[p]].src2     = bus_if.dis_src2[p];
            entry_d[alloc_idx[p]].src1_rdy = bus_if.dis_src1_rdy[p] |
               wake_hit(bus_if.dis_src1[p], bus_if.wk_valid, bus_if.wk_index);
            entry_d[alloc_idx[p]].src2_rdy = bus_if.dis_src2_rdy[p] |
               wake_hit(bus_if.dis_src2[p], bus_if.wk_valid, bus_if.wk_index);
            for (int j = 0; j < DEPTH; j++) begin
               age_d[j][alloc_idx[p]] = 1'b1;
               age_d[alloc_idx[p]][j] = 1'b0;
            end
            age_d[alloc_idx[p]][alloc_idx[p]] = 1'b0;
         end
      end
      if (flush_i) begin
         valid_d = '0;
      end
   end

   // Valid bits and age matrix, cleared asynchronously by reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= '0;
         age_q   <= '0;
      end else begin
         valid_q <= valid_d;
         age_q   <= age_d;
      end
   end

   // Payload, tags and operand-ready bits; qualified by valid so no reset.
   always_ff @(posedge clk_i) begin
      entry_q <= entry_d;
   end

endmodule
`default_nettype wire

// File: tb/tb_issue_queue_age.sv
`default_nettype none
// ============================================================================
// Module   : tb_issue_queue_age
// Purpose  : Directed self-checking bench for issue_queue_age.
// Revision : 1.0 - initial release
// ============================================================================
module tb_issue_queue_age;
   import iq_pkg::*;

   localparam int DEPTH = 16;
   localparam int DW    = 4;
   localparam int IW    = 4;
   localparam int WW    = 4;
   localparam int TW    = 6;
   localparam int PW    = 32;

   logic clk_i   = 1'b0;
   logic rst_ni  = 1'b0;
   logic flush_i = 1'b0;

   issue_queue_age_if #(
      .DEPTH(DEPTH), .DISPATCH_W(DW), .ISSUE_W(IW),
      .WAKEUP_W(WW), .PRF_IDX_W(TW), .PAYLOAD_W(PW)
   ) bus_if ();

   issue_queue_age #(
      .DEPTH(DEPTH), .DISPATCH_W(DW), .ISSUE_W(IW),
      .WAKEUP_W(WW), .PRF_IDX_W(TW), .PAYLOAD_W(PW)
   ) dut (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .flush_i (flush_i),
      .bus_if  (bus_if)
   );

   always #5 clk_i = ~clk_i;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      bus_if.dis_valid    = '0;
      bus_if.dis_payload  = '0;
      bus_if.dis_src1     = '0;
      bus_if.dis_src2     = '0;
      bus_if.dis_src1_rdy = '0;
      bus_if.dis_src2_rdy = '0;
      bus_if.wk_valid     = '0;
      bus_if.wk_index     = '0;
      flush_i             = 1'b0;
   endtask

   task automatic set_dis(input int p, input logic [31:0] pl,
                          input logic [5:0] s1, input logic r1,
                          input logic [5:0] s2, input logic r2);
      bus_if.dis_valid[p]    = 1'b1;
      bus_if.dis_payload[p]  = pl;
      bus_if.dis_src1[p]     = s1;
      bus_if.dis_src1_rdy[p] = r1;
      bus_if.dis_src2[p]     = s2;
      bus_if.dis_src2_rdy[p] = r2;
   endtask

   task automatic next();
      @(posedge clk_i);
      #1;
   endtask

   task automatic at_neg();
      @(negedge clk_i);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      idle();
      bus_if.ex_busy = '0;
      #12;
      check("rst_iss_valid", 64'(bus_if.iss_valid), 64'h0);
      check("rst_full", 64'(bus_if.iq_full), 64'h0);
      check("rst_free", 64'(bus_if.free_count), 64'd16);
      at_neg();
      rst_ni = 1'b1;
      next();

      // 4 ready uops: issue next cycle in port order
      for (int p = 0; p < 4; p++) set_dis(p, 32'hA0 + p, 6'd1, 1'b1, 6'd2, 1'b1);
      at_neg();
      check("t1_no_same_cycle", 64'(bus_if.iss_valid), 64'h0);
      next(); idle();
      at_neg();
      check("t1_iss_valid", 64'(bus_if.iss_valid), 64'hF);
      for (int i = 0; i < 4; i++)
         check($sformatf("t1_pl%0d", i), 64'(bus_if.iss_payload[i]), 64'hA0 + i);
      check("t1_free12", 64'(bus_if.free_count), 64'd12);
      next();
      at_neg();
      check("t1_free16", 64'(bus_if.free_count), 64'd16);
      check("t1_idle", 64'(bus_if.iss_valid), 64'h0);
      next();

      // fill with 16 uops waiting on tag 5
      for (int b = 0; b < 4; b++) begin
         for (int p = 0; p < 4; p++) set_dis(p, 32'h100 + b*4 + p, 6'd5, 1'b0, 6'd3, 1'b1);
         if (b == 3) begin
            at_neg();
            check("t2_free4", 64'(bus_if.free_count), 64'd4);
            check("t2_not_full", 64'(bus_if.iq_full), 64'h0);
         end
         next();
      end
      for (int p = 0; p < 4; p++) set_dis(p, 32'hDEAD0 + p, 6'd0, 1'b1, 6'd0, 1'b1);
      at_neg();
      check("t2_full", 64'(bus_if.iq_full), 64'h1);
      check("t2_free0", 64'(bus_if.free_count), 64'd0);
      check("t2_sleep", 64'(bus_if.iss_valid), 64'h0);
      next(); idle();
      bus_if.wk_valid    = 4'b0001;
      bus_if.wk_index[0] = 6'd5;
      at_neg();
      check("t2_ignored", 64'(bus_if.free_count), 64'd0);
      next(); idle();
      at_neg();
      check("t2_iss_valid", 64'(bus_if.iss_valid), 64'hF);
      for (int i = 0; i < 4; i++)
         check($sformatf("t2_b0_pl%0d", i), 64'(bus_if.iss_payload[i]), 64'h100 + i);
      next();
      at_neg();
      for (int i = 0; i < 4; i++)
         check($sformatf("t2_b1_pl%0d", i), 64'(bus_if.iss_payload[i]), 64'h104 + i);
      check("t2_free4b", 64'(bus_if.free_count), 64'd4);
      next(); next(); next();
      at_neg();
      check("t2_drained", 64'(bus_if.free_count), 64'd16);
      next();

      // age order vs. index order with a busy port 0
      bus_if.ex_busy = 4'b1111;
      set_dis(0, 32'h300, 6'd1, 1'b1, 6'd1, 1'b1);
      set_dis(1, 32'h301, 6'd1, 1'b1, 6'd1, 1'b1);
      next(); idle();
      bus_if.ex_busy = 4'b1110;
      at_neg();
      check("t3_p_valid", 64'(bus_if.iss_valid), 64'h1);
      check("t3_p_pl", 64'(bus_if.iss_payload[0]), 64'h300);
      next();
      bus_if.ex_busy = 4'b1111;
      set_dis(0, 32'h302, 6'd1, 1'b1, 6'd1, 1'b1);
      at_neg();
      check("t3_all_busy", 64'(bus_if.iss_valid), 64'h0);
      next(); idle();
      bus_if.ex_busy = 4'b0001;
      at_neg();
      check("t3_skip_valid", 64'(bus_if.iss_valid), 64'h6);
      check("t3_port1_A", 64'(bus_if.iss_payload[1]), 64'h301);
      check("t3_port2_B", 64'(bus_if.iss_payload[2]), 64'h302);
      next();
      bus_if.ex_busy = 4'b0000;
      at_neg();
      check("t3_free16", 64'(bus_if.free_count), 64'd16);
      next();

      // wakeup in the dispatch cycle; unrelated tag stays asleep; tag 0
      set_dis(0, 32'h400, 6'd11, 1'b1, 6'd9, 1'b0);
      set_dis(1, 32'h401, 6'd12, 1'b1, 6'd10, 1'b0);
      bus_if.wk_valid    = 4'b0100;
      bus_if.wk_index[2] = 6'd9;
      next(); idle();
      at_neg();
      check("t4_same_cycle_wk", 64'(bus_if.iss_valid), 64'h1);
      check("t4_pl_x", 64'(bus_if.iss_payload[0]), 64'h400);
      next();
      bus_if.wk_valid    = 4'b1000;
      bus_if.wk_index[3] = 6'd10;
      at_neg();
      check("t4_y_asleep", 64'(bus_if.iss_valid), 64'h0);
      next(); idle();
      at_neg();
      check("t4_y_valid", 64'(bus_if.iss_valid), 64'h1);
      check("t4_pl_y", 64'(bus_if.iss_payload[0]), 64'h401);
      next();
      set_dis(2, 32'h402, 6'd0, 1'b0, 6'd13, 1'b1);
      next(); idle();
      at_neg();
      check("t4_tag0_asleep", 64'(bus_if.iss_valid), 64'h0);
      next();
      bus_if.wk_valid    = 4'b0010;
      bus_if.wk_index[1] = 6'd0;
      next(); idle();
      at_neg();
      check("t4_tag0_valid", 64'(bus_if.iss_valid), 64'h1);
      check("t4_pl_z", 64'(bus_if.iss_payload[0]), 64'h402);
      next();

      // flush with 8 resident entries and a dispatch pending
      bus_if.ex_busy = 4'b1111;
      for (int p = 0; p < 4; p++) set_dis(p, 32'h500 + p, 6'd1, 1'b1, 6'd1, 1'b1);
      next();
      for (int p = 0; p < 4; p++) set_dis(p, 32'h510 + p, 6'd20, 1'b0, 6'd1, 1'b1);
      at_neg();
      check("t5_free12", 64'(bus_if.free_count), 64'd12);
      next(); idle();
      bus_if.ex_busy = 4'b0000;
      flush_i = 1'b1;
      for (int p = 0; p < 4; p++) set_dis(p, 32'h520 + p, 6'd1, 1'b1, 6'd1, 1'b1);
      at_neg();
      check("t5_flush_iss", 64'(bus_if.iss_valid), 64'h0);
      check("t5_free8", 64'(bus_if.free_count), 64'd8);
      next(); idle();
      at_neg();
      check("t5_free16", 64'(bus_if.free_count), 64'd16);
      check("t5_post_iss", 64'(bus_if.iss_valid), 64'h0);
      next();

      // asynchronous reset in the middle of traffic
      bus_if.ex_busy = 4'b1111;
      for (int p = 0; p < 4; p++) set_dis(p, 32'h600 + p, 6'd1, 1'b1, 6'd1, 1'b1);
      next(); idle();
      bus_if.ex_busy = 4'b0000;
      #1;
      check("t6_pre_iss", 64'(bus_if.iss_valid), 64'hF);
      rst_ni = 1'b0;
      #1;
      check("t6_rst_iss", 64'(bus_if.iss_valid), 64'h0);
      check("t6_rst_free", 64'(bus_if.free_count), 64'd16);
      check("t6_rst_full", 64'(bus_if.iq_full), 64'h0);
      at_neg();
      rst_ni = 1'b1;
      next();
      set_dis(2, 32'h777, 6'd1, 1'b1, 6'd1, 1'b1);
      next(); idle();
      at_neg();
      check("t6_post_iss", 64'(bus_if.iss_valid), 64'h1);
      check("t6_post_pl", 64'(bus_if.iss_payload[0]), 64'h777);
      check("t6_post_free", 64'(bus_if.free_count), 64'd15);
      next();
      at_neg();
      check("t6_end_free", 64'(bus_if.free_count), 64'd16);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
